// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and defaults for the systolic array sequencer
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } ctrl_state_t;

    localparam int DATA_SIZE_DEF = 8;
    localparam int SIZE_DEF      = 3;

    // Cycles from a data row entering the array to its result leaving it.
    function automatic int lat_def(input int size);
        return 2 * size - 1;
    endfunction

endpackage

// File: rtl/valid_delay.sv
// rtl/valid_delay.sv - tag shift register with synchronous active-low clear
module valid_delay #(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer wrapping a weight-stationary systolic array in valid/ready streams
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int SIZE      = SIZE_DEF,
    parameter int LATENCY   = lat_def(SIZE),
    parameter int ROW_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ROW_W-1:0]          num_rows,
    output logic                      busy,
    output logic                      done,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [DATA_SIZE*SIZE-1:0] w_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_SIZE*SIZE-1:0] in_data,
    output logic                      arr_set_w,
    output logic [DATA_SIZE*SIZE-1:0] arr_w_stream,
    output logic [DATA_SIZE*SIZE-1:0] arr_data_stream,
    input  logic [DATA_SIZE*SIZE-1:0] arr_y_stream,
    output logic                      y_valid,
    output logic [DATA_SIZE*SIZE-1:0] y_data
);

    localparam logic [ROW_W-1:0] W_LAST = ROW_W'(SIZE - 1);
    localparam logic [ROW_W-1:0] F_LAST = ROW_W'(LATENCY);
    localparam logic [ROW_W-1:0] ONE    = ROW_W'(1);

    ctrl_state_t      state, state_next;
    logic [ROW_W-1:0] rows_q;
    logic [ROW_W-1:0] wcnt;
    logic [ROW_W-1:0] dcnt;
    logic [ROW_W-1:0] fcnt;
    logic             w_hs;
    logic             in_hs;

    assign w_hs  = (state == ST_LOAD_W) && w_valid;
    assign in_hs = (state == ST_STREAM) && in_valid;

    always_comb begin
        state_next = state;
        w_ready    = 1'b0;
        in_ready   = 1'b0;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && wcnt == W_LAST) begin
                    state_next = (rows_q == '0) ? ST_FLUSH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                in_ready = 1'b1;
                if (in_valid && dcnt == rows_q - ONE) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (fcnt == F_LAST) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            rows_q          <= '0;
            wcnt            <= '0;
            dcnt            <= '0;
            fcnt            <= '0;
            arr_set_w       <= 1'b0;
            arr_w_stream    <= '0;
            arr_data_stream <= '0;
        end else begin
            state     <= state_next;
            arr_set_w <= w_hs;
            if (w_hs) arr_w_stream <= w_data;
            // Non-accept cycles feed zero rows so the array never sees stale data.
            arr_data_stream <= in_hs ? in_data : '0;
            if (state == ST_IDLE && start) begin
                rows_q <= num_rows;
                wcnt   <= '0;
                dcnt   <= '0;
                fcnt   <= '0;
            end else begin
                if (w_hs)               wcnt <= wcnt + ONE;
                if (in_hs)              dcnt <= dcnt + ONE;
                if (state == ST_FLUSH)  fcnt <= fcnt + ONE;
            end
        end
    end

    // One stage more than LATENCY because the row register itself adds a cycle.
    valid_delay #(
        .DEPTH (LATENCY + 1)
    ) u_tags (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in_hs),
        .dout  (y_valid)
    );

    assign y_data = arr_y_stream;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - randomized self-checking bench for systolic_ctrl with a behavioural array stub
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int DS   = 8;
    localparam int SZ   = 3;
    localparam int LAT  = lat_def(SZ);
    localparam int RW   = 8;
    localparam int W    = DS * SZ;
    localparam int RING = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] num_rows = '0;
    logic          busy, done;
    logic          w_valid = 1'b0, w_ready;
    logic [W-1:0]  w_data = '0;
    logic          in_valid = 1'b0, in_ready;
    logic [W-1:0]  in_data = '0;
    logic          arr_set_w;
    logic [W-1:0]  arr_w_stream, arr_data_stream, arr_y_stream;
    logic          y_valid;
    logic [W-1:0]  y_data;

    always #5 clk = ~clk;

    systolic_ctrl #(
        .DATA_SIZE (DS),
        .SIZE      (SZ),
        .LATENCY   (LAT),
        .ROW_W     (RW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .num_rows        (num_rows),
        .busy            (busy),
        .done            (done),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_data          (w_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .arr_set_w       (arr_set_w),
        .arr_w_stream    (arr_w_stream),
        .arr_data_stream (arr_data_stream),
        .arr_y_stream    (arr_y_stream),
        .y_valid         (y_valid),
        .y_data          (y_data)
    );

    // y = x * Wmat, row k of Wmat being the k-th weight row shifted in, mod 2^DS
    function automatic logic [W-1:0] matvec(input logic [W-1:0] x, input logic [SZ-1:0][W-1:0] m);
        logic [W-1:0]  r;
        logic [DS-1:0] acc;
        r = '0;
        for (int j = 0; j < SZ; j++) begin
            acc = '0;
            for (int k = 0; k < SZ; k++) acc = acc + x[k*DS +: DS] * m[k][j*DS +: DS];
            r[j*DS +: DS] = acc;
        end
        return r;
    endfunction

    // Behavioural array: captures weight rows in arrival order, answers LAT cycles later.
    logic [SZ-1:0][W-1:0] wreg;
    int                   widx;
    logic [W-1:0]         pipe [LAT];

    always @(posedge clk) begin
        if (!rst_n) begin
            wreg <= '0;
            widx <= 0;
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            if (arr_set_w) begin
                wreg[widx] <= arr_w_stream;
                widx       <= (widx + 1) % SZ;
            end
            pipe[0] <= matvec(arr_data_stream, wreg);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign arr_y_stream = pipe[LAT-1];

    logic                 exp_setw [RING];
    logic [W-1:0]         exp_ws   [RING];
    logic [W-1:0]         exp_ads  [RING];
    logic                 exp_yv   [RING];
    logic [W-1:0]         exp_yd   [RING];
    logic [W-1:0]         last_w;
    logic [SZ-1:0][W-1:0] jw;
    int                   cyc;
    int                   n_chk = 0;
    int                   n_pass = 0;

    task automatic clear_rings();
        for (int i = 0; i < RING; i++) begin
            exp_setw[i] = 1'b0;
            exp_ws[i]   = '0;
            exp_ads[i]  = '0;
            exp_yv[i]   = 1'b0;
            exp_yd[i]   = '0;
        end
        last_w = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Check one cycle's outputs at the falling edge, then advance past the rising edge.
    task automatic tick(input logic eb, input logic ewr, input logic eir, input logic edone);
        int s;
        s = cyc % RING;
        @(negedge clk);
        check("busy", 32'(busy), 32'(eb));
        check("w_ready", 32'(w_ready), 32'(ewr));
        check("in_ready", 32'(in_ready), 32'(eir));
        check("done", 32'(done), 32'(edone));
        check("arr_set_w", 32'(arr_set_w), 32'(exp_setw[s]));
        if (exp_setw[s]) last_w = exp_ws[s];
        check("arr_w_stream", 32'(arr_w_stream), 32'(last_w));
        check("arr_data_stream", 32'(arr_data_stream), 32'(exp_ads[s]));
        check("y_valid", 32'(y_valid), 32'(exp_yv[s]));
        if (exp_yv[s]) check("y_data", 32'(y_data), 32'(exp_yd[s]));
        exp_setw[s] = 1'b0;
        exp_ads[s]  = '0;
        exp_yv[s]   = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // wmode: 0 always valid, 1 random, 2 low on 2nd cycle. imode: 0 always, 1 random, 2 toggle.
    // abort_at >= 0 resets the DUT once that many rows have been accepted.
    task automatic run_job(input int nrows, input int wmode, input int imode,
                           input bit hold_next, input int abort_at);
        int           k, wc, j, rc;
        logic         v;
        logic [W-1:0] row;
        start    = 1'b1;
        num_rows = RW'(nrows);
        w_valid  = 1'($urandom);
        w_data   = W'($urandom);
        in_valid = 1'($urandom);
        in_data  = W'($urandom);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;

        k = 0;
        wc = 0;
        while (k < SZ) begin
            case (wmode)
                0:       v = 1'b1;
                2:       v = (wc != 1);
                default: v = 1'($urandom) | (wc > 20);
            endcase
            if (wmode == 1) row = W'($urandom);
            else row = {8'(3*k+3), 8'(3*k+2), 8'(3*k+1)};
            w_valid  = v;
            w_data   = v ? row : W'($urandom);
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            start    = 1'($urandom);
            if (v) begin
                jw[k] = row;
                exp_setw[(cyc+1) % RING] = 1'b1;
                exp_ws[(cyc+1) % RING]   = row;
                k++;
            end
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            wc++;
        end

        j = 0;
        rc = 0;
        while (j < nrows) begin
            if (abort_at >= 0 && j == abort_at) begin
                rst_n    = 1'b0;
                start    = 1'b0;
                in_valid = 1'b0;
                w_valid  = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                cyc += 2;
                clear_rings();
                return;
            end
            case (imode)
                0:       v = 1'b1;
                2:       v = (rc % 2 == 0);
                default: v = 1'($urandom) | (rc > 30);
            endcase
            in_valid = v;
            in_data  = W'($urandom);
            w_valid  = 1'($urandom);
            w_data   = W'($urandom);
            start    = 1'($urandom);
            if (v) begin
                exp_ads[(cyc+1) % RING]    = in_data;
                exp_yv[(cyc+1+LAT) % RING] = 1'b1;
                exp_yd[(cyc+1+LAT) % RING] = matvec(in_data, jw);
                j++;
            end
            tick(1'b1, 1'b0, 1'b1, 1'b0);
            rc++;
        end

        for (int f = 0; f <= LAT; f++) begin
            in_valid = 1'($urandom);
            w_valid  = 1'($urandom);
            start    = 1'($urandom);
            tick(1'b1, 1'b0, 1'b0, 1'b0);
        end

        in_valid = 1'b0;
        w_valid  = 1'b0;
        start    = hold_next;
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0;
        clear_rings();
        jw = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        run_job(6, 0, 0, 1'b0, -1);
        run_job(4, 2, 2, 1'b0, -1);
        run_job(0, 0, 0, 1'b0, -1);
        run_job(5, 0, 1, 1'b0, 2);
        run_job(4, 1, 1, 1'b0, -1);
        run_job(3, 1, 0, 1'b1, -1);
        run_job(2, 0, 1, 1'b0, -1);
        run_job(40, 1, 1, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            run_job($urandom_range(1, 12), 1, 1, (i < 5) ? 1'($urandom) : 1'b0, -1);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer placed in front of the `systolic` weight-stationary array.
- Per job, it shifts `SIZE` weight rows into the array using `set_w`, then streams `num_rows` input rows, then flushes with zero rows.
- It tags each result row on `y_stream` with a valid bit, so downstream logic sees only real products.
- It converts the array's free-running, handshake-less ports into valid/ready streams with a start/done job interface.

## Interface
- `DATA_SIZE`, 8: bits per element.
- `SIZE`, 3: array dimension (rows/columns).
- `LATENCY`, 2*SIZE-1: cycles from a data row being present on `arr_data_stream` to its result on `arr_y_stream`.
- `ROW_W`, 8: width of the row count.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: job request, sampled in IDLE only.
- `num_rows` in ROW_W: data rows for the job, latched on accepted `start`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at job end.
- `w_valid`, `w_ready`, `w_data[DATA_SIZE*SIZE]`: weight row stream (in, out, in).
- `in_valid`, `in_ready`, `in_data[DATA_SIZE*SIZE]`: data row stream (in, out, in).
- `arr_set_w` out 1, `arr_w_stream` out DATA_SIZE*SIZE, `arr_data_stream` out DATA_SIZE*SIZE: drive the array.
- `arr_y_stream` in DATA_SIZE*SIZE: array result.
- `y_valid` out 1, `y_data` out DATA_SIZE*SIZE: tagged result; `y_data` equals `arr_y_stream`. No backpressure.

## Operation
- States: IDLE, LOAD_W, STREAM, FLUSH, DONE.
- **IDLE:** if `start` is high, latch `num_rows` and go to LOAD_W. Otherwise stay.
- **LOAD_W:**
  - `w_ready` = 1.
  - On each `w_valid & w_ready`: register `arr_set_w` = 1 and `arr_w_stream` = `w_data`, and increment `wcnt`.
  - On cycles without a handshake, `arr_set_w` = 0.
  - After the SIZE-th handshake, go to STREAM, or to FLUSH if the latched `num_rows` = 0.
- **STREAM:**
  - `in_ready` = 1.
  - On a handshake: `arr_data_stream` <= `in_data`, push tag 1, increment `dcnt`.
  - Otherwise: `arr_data_stream` <= 0, push tag 0 (bubble).
  - After the `num_rows`-th handshake, go to FLUSH.
- **FLUSH:** `arr_data_stream` <= 0, push tag 0. Stay LATENCY+1 cycles, counted by `fcnt`, then go to DONE.
- **DONE:** `done` = 1 for one cycle, then go to IDLE.
- `arr_data_stream` is 0 in IDLE, LOAD_W and DONE.
- `arr_w_stream` holds its last value when `arr_set_w` = 0.
- `w_ready` and `in_ready` are combinational from state only; they do not depend on the valids.
- `start` while busy is ignored.
- `w_valid` outside LOAD_W and `in_valid` outside STREAM are ignored and not consumed.
- Counters `wcnt`, `dcnt` and `fcnt` clear on entry to LOAD_W.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - State goes to IDLE.
  - All `arr_*` outputs go to 0.
  - `busy`, `done`, `y_valid` go to 0.
  - The tag line clears.
  - All counters clear.
  - Reset mid-job abandons the job with no `done` pulse.
- `start` sampled at edge T0: `busy` = 1 from cycle T0+1.
- Weight handshake at edge T: `arr_set_w` = 1 during cycle T+1 only.
- Data row accepted at edge T: on `arr_data_stream` during cycle T+1; `y_valid` = 1 during cycle T+1+LATENCY.
- Tag delay line is LATENCY+1 stages. Rows accepted on back-to-back edges give back-to-back `y_valid` cycles. Bubbles appear as `y_valid` = 0 at the same offset.
- Last data accept at edge TL:
  - FLUSH occupies cycles TL+1 .. TL+LATENCY+1.
  - The last `y_valid` is in cycle TL+LATENCY+1.
  - `done` is in cycle TL+LATENCY+2.
  - `busy` falls in cycle TL+LATENCY+3.
- Minimum job length with no stalls: 1 + SIZE + num_rows + LATENCY+1 + 1 cycles.
- `num_rows` = 2^ROW_W-1 is legal. Counters are ROW_W bits and never wrap within a job.

## Structure
- Shared package `systolic_pkg`:
  - state enum `ctrl_state_t`;
  - default constants `DATA_SIZE_DEF`, `SIZE_DEF`;
  - function `lat_def(size)` = 2*size-1.
- One sub-module, `valid_delay` (params `DEPTH`): a shift register of tags with synchronous active-low clear.
- The remaining state machine, counters and registered array drivers stay in `systolic_ctrl`.

## Test plan
All scenarios use SIZE=3, LATENCY=5.
- **Reset:** assert `rst_n` = 0 for 2 cycles mid-STREAM -> next cycle `busy`, `y_valid`, `arr_set_w` = 0 and `arr_data_stream` = 0. A following `start` runs a full job correctly.
- **Nominal:**
  - Stimulus: weights {1 2 3},{4 5 6},{7 8 9}; `num_rows` = 6; inputs always valid.
  - `arr_set_w` is high for exactly 3 consecutive cycles.
  - Exactly 6 `y_valid` cycles, contiguous, the first 6 cycles after the first row is applied.
  - `y_data` matches the golden product.
  - `done` pulses 7 cycles after the last accept.
- **Stalls:**
  - Stimulus: `w_valid` low on the 2nd weight cycle; `in_valid` toggling 1,0,1,0.
  - `arr_set_w` shows a 1-0-1-1 pattern.
  - `y_valid` reproduces the 1,0,1,0 gaps, shifted by 6 cycles.
- **num_rows = 0:** after 3 weight handshakes -> FLUSH for 6 cycles, then `done`. No `y_valid` at any point.
- **Ignored inputs:**
  - `start` pulsed during STREAM -> no effect.
  - `in_valid` high during LOAD_W -> `in_ready` = 0 and no row is consumed.
- **Back-to-back jobs:** `start` held high across DONE -> a new job begins the cycle after returning to IDLE, and the weights reload.
